// File: rtl/lab8_pio_pkg.sv
// Shared constants, edge-type encoding and counter sizing for the lab8 key PIO.
package lab8_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Counter must hold DEB_CYCLES-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned deb_cycles);
    int unsigned w;
    w = $clog2(deb_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/lab8_pio_debounce.sv
// One input channel: 2-FF synchroniser followed by a stability debouncer.
// Debounce counter only exists when LAB8_PIO_DEBOUNCE_EN is defined; otherwise stable follows sync.
module lab8_pio_debounce
  import lab8_pio_pkg::*;
#(
`ifdef LAB8_PIO_DEBOUNCE_EN
  parameter int unsigned DebCycles  = 50000,
`endif
  parameter logic        ResetLevel = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic stable_o
);

  logic sync1_q, sync2_q;
  logic stable_q, stable_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= ResetLevel;
      sync2_q  <= ResetLevel;
      stable_q <= ResetLevel;
    end else begin
      sync1_q  <= pin_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
    end
  end

`ifdef LAB8_PIO_DEBOUNCE_EN
  localparam int unsigned     CntW   = cnt_width(DebCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(DebCycles - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StCount = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (sync2_q != stable_q) begin
          state_d = StCount;
        end
      end
      StCount: begin
        // Any agreeing cycle is treated as bounce and restarts the wait.
        if (sync2_q == stable_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          stable_d = sync2_q;
          state_d  = StIdle;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  always_comb begin
    stable_d = sync2_q;
  end
`endif

  assign stable_o = stable_q;

endmodule

// File: rtl/lab8_soc_key_pio.sv
// Avalon-MM input PIO: per-bit debounced level, sticky edge capture (W1C), maskable level IRQ.
// Debouncing is enabled by defining LAB8_PIO_DEBOUNCE_EN.
module lab8_soc_key_pio
  import lab8_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned EDGE_TYPE   = 1,
  parameter logic        RESET_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32 || DEB_CYCLES < 2 || EDGE_TYPE > 2) begin : g_bad_params
    $error("lab8_soc_key_pio: illegal parameter value");
  end

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise, fall, edge_det;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] clr;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    lab8_pio_debounce #(
`ifdef LAB8_PIO_DEBOUNCE_EN
      .DebCycles  (DEB_CYCLES),
`endif
      .ResetLevel (RESET_LEVEL)
    ) u_debounce (
      .clk_i    (clk),
      .rst_i    (reset),
      .pin_i    (in_port[i]),
      .stable_o (stable[i])
    );
  end

  assign wr_en        = chipselect & write;
  assign unused_wdata = ^writedata;

  always_comb begin
    rise = stable & ~prev_q;
    fall = ~stable & prev_q;
    if (EDGE_TYPE == 32'(EDGE_RISE)) begin
      edge_det = rise;
    end else if (EDGE_TYPE == 32'(EDGE_FALL)) begin
      edge_det = fall;
    end else begin
      edge_det = rise | fall;
    end
  end

  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && address == ADDR_MASK) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == ADDR_EDGE) begin
      clr = writedata[WIDTH-1:0];
    end
    // OR-ing the edge in last lets a new capture win over a simultaneous clear.
    cap_d = (cap_q & ~clr) | edge_det;
    irq_d = |(cap_q & mask_q);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = stable;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = cap_q;
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= {WIDTH{RESET_LEVEL}};
      mask_q     <= '0;
      cap_q      <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      prev_q     <= stable;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_lab8_soc_key_pio.sv
// Directed bench for lab8_soc_key_pio (WIDTH=4, DEB_CYCLES=8, falling-edge capture).
module tb_lab8_soc_key_pio;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEB   = 8;
`ifdef LAB8_PIO_DEBOUNCE_EN
  localparam int          LAT       = 2 + DEB + 1;
  localparam logic [31:0] PULSE_CAP = 32'h0;
`else
  localparam int          LAT       = 3;
  localparam logic [31:0] PULSE_CAP = 32'h8;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  int n_vec = 0;
  int n_err = 0;

  lab8_soc_key_pio #(
    .WIDTH       (WIDTH),
    .DEB_CYCLES  (DEB),
    .EDGE_TYPE   (1),
    .RESET_LEVEL (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write      = 1'b1;
    tick(1);
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    tick(1);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    in_port    = 4'hF;

    // Reset held while pins toggle: outputs stay zero
    for (int i = 0; i < 8; i++) begin
      in_port = 4'(i * 5);
      address = 2'(i);
      tick(1);
      check_eq("rst_readdata", readdata, 32'h0);
      check_eq("rst_irq", {31'b0, irq}, 32'h0);
    end
    in_port = 4'hF;
    tick(1);
    reset = 1'b0;
    tick(LAT + 2);
    bus_read(2'd0, rd); check_eq("post_rst_data", rd, 32'hF);
    bus_read(2'd3, rd); check_eq("post_rst_cap", rd, 32'h0);
    check_eq("post_rst_irq", {31'b0, irq}, 32'h0);

`ifdef LAB8_PIO_DEBOUNCE_EN
    // 7-cycle glitch is shorter than the debounce window
    in_port[0] = 1'b0;
    tick(7);
    in_port[0] = 1'b1;
    tick(LAT + 4);
    bus_read(2'd0, rd); check_eq("glitch_data", rd, 32'hF);
    bus_read(2'd3, rd); check_eq("glitch_cap", rd, 32'h0);
`endif

    // Latency: stable flips LAT edges after the pin, readdata one edge later
    address    = 2'd0;
    in_port[0] = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick(1);
      check_eq($sformatf("lat_k%0d", k), readdata, (k <= LAT) ? 32'hF : 32'hE);
    end

    // Key0 falling edge captured while masked
    bus_read(2'd3, rd); check_eq("key0_cap", rd, 32'h1);
    check_eq("key0_irq_masked", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'h1);
    check_eq("mask1_irq_lag", {31'b0, irq}, 32'h0);
    tick(1);
    check_eq("mask1_irq", {31'b0, irq}, 32'h1);

    // W1C clears capture; irq follows one cycle later
    bus_write(2'd3, 32'h1);
    check_eq("w1c_irq_lag", {31'b0, irq}, 32'h1);
    tick(1);
    check_eq("w1c_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd3, rd); check_eq("w1c_cap", rd, 32'h0);

    // Release key0: rising edge not captured
    in_port[0] = 1'b1;
    tick(LAT + 3);
    bus_read(2'd3, rd); check_eq("rise_ignored", rd, 32'h0);
    bus_read(2'd0, rd); check_eq("rel_data", rd, 32'hF);

    // Key2 pressed with mask = 0, then unmask
    bus_write(2'd2, 32'h0);
    in_port[2] = 1'b0;
    tick(LAT + 3);
    bus_read(2'd3, rd); check_eq("key2_cap", rd, 32'h4);
    check_eq("key2_irq_masked", {31'b0, irq}, 32'h0);
    bus_write(2'd2, 32'h4);
    check_eq("mask4_irq_lag", {31'b0, irq}, 32'h0);
    tick(1);
    check_eq("mask4_irq", {31'b0, irq}, 32'h1);
    bus_read(2'd2, rd); check_eq("mask_rd", rd, 32'h4);

    // Write without chipselect ignored; reserved address ignored and reads zero
    address   = 2'd2;
    writedata = 32'h0;
    write     = 1'b1;
    tick(1);
    write     = 1'b0;
    bus_read(2'd2, rd); check_eq("nocs_write", rd, 32'h4);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rd); check_eq("rsvd_rd", rd, 32'h0);
    bus_write(2'd2, 32'hFFFF_FFF0);
    bus_read(2'd2, rd); check_eq("mask_upper", rd, 32'h0);
    check_eq("mask_upper_irq", {31'b0, irq}, 32'h0);

    // Edge and W1C of the same bit on the same edge: set wins
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, rd); check_eq("pre_race_cap", rd, 32'h0);
    in_port[1] = 1'b0;
    tick(LAT);
    address    = 2'd3;
    writedata  = 32'h2;
    chipselect = 1'b1;
    write      = 1'b1;
    tick(1);
    chipselect = 1'b0;
    write      = 1'b0;
    bus_read(2'd3, rd); check_eq("race_cap", rd, 32'h2);
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, rd); check_eq("race_cleared", rd, 32'h0);

    // Two-cycle pulse on key3
    in_port[3] = 1'b0;
    tick(2);
    in_port[3] = 1'b1;
    tick(LAT + 4);
    bus_read(2'd3, rd); check_eq("pulse_cap", rd, PULSE_CAP);
    bus_read(2'd0, rd); check_eq("pulse_data", rd, 32'h9);

    // Reset mid-capture returns everything to reset values
    bus_write(2'd2, 32'hF);
    reset = 1'b1;
    tick(1);
    check_eq("rst2_readdata", readdata, 32'h0);
    check_eq("rst2_irq", {31'b0, irq}, 32'h0);
    in_port = 4'hF;
    tick(2);
    reset = 1'b0;
    tick(LAT + 3);
    bus_read(2'd3, rd); check_eq("rst2_cap", rd, 32'h0);
    bus_read(2'd2, rd); check_eq("rst2_mask", rd, 32'h0);
    bus_read(2'd0, rd); check_eq("rst2_data", rd, 32'hF);
    check_eq("rst2_irq_after", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
